// File: rtl/ec_scalar_ctrl.sv
// Scalar-multiplication sequencer: computes R = k*P by left-to-right double-and-add,
// delegating each non-trivial point add/double to an external engine.
module ec_scalar_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] in_k,
  input  logic [5:0] in_Px,
  input  logic [5:0] in_Py,
  input  logic [5:0] in_prime,
  input  logic [5:0] in_a,
  output logic       ec_in_valid,
  output logic [5:0] ec_Px,
  output logic [5:0] ec_Py,
  output logic [5:0] ec_Qx,
  output logic [5:0] ec_Qy,
  output logic [5:0] ec_prime,
  output logic [5:0] ec_a,
  input  logic       ec_out_valid,
  input  logic [5:0] ec_Rx,
  input  logic [5:0] ec_Ry,
  output logic       out_valid,
  output logic [5:0] out_Rx,
  output logic [5:0] out_Ry,
  output logic       out_inf,
  output logic [2:0] dbg_state
);

  // Handshake: ec_in_valid is a one-cycle start pulse with operands valid in that
  // cycle and held until the engine's one-cycle ec_out_valid; no backpressure.
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DBL      = 3'd1;
  localparam logic [2:0] DBL_WAIT = 3'd2;
  localparam logic [2:0] ADD      = 3'd3;
  localparam logic [2:0] ADD_WAIT = 3'd4;
  localparam logic [2:0] NEXT     = 3'd5;
  localparam logic [2:0] OUT      = 3'd6;

  logic [2:0] state;
  logic [2:0] idx;
  logic [5:0] k_r;
  logic [5:0] px_r;
  logic [5:0] py_r;
  logic [5:0] prime_r;
  logic [5:0] a_r;
  logic [5:0] acc_x;
  logic [5:0] acc_y;
  logic       acc_inf;
  logic [5:0] q_x;
  logic [5:0] q_y;

  logic k_bit;
  logic dbl_call;
  logic add_inv;
  logic add_two;
  logic add_call;

  always_comb begin
    k_bit    = k_r[idx];
    dbl_call = (state == DBL) && !acc_inf && (acc_y != 6'd0);
    add_inv  = (acc_x == px_r) && (acc_y != py_r);
    add_two  = (acc_x == px_r) && (acc_y == py_r) && (py_r == 6'd0);
    add_call = (state == ADD) && k_bit && !acc_inf && !add_inv && !add_two;
  end

  // The engine's first operand is always the accumulator; the second is staged in
  // q (acc before a double, the base point before an add) so both come from flops.
  assign ec_in_valid = dbl_call || add_call;
  assign ec_Px       = acc_x;
  assign ec_Py       = acc_y;
  assign ec_Qx       = q_x;
  assign ec_Qy       = q_y;
  assign ec_prime    = prime_r;
  assign ec_a        = a_r;

  assign out_valid = (state == OUT);
  assign out_inf   = out_valid && acc_inf;
  assign out_Rx    = (out_valid && !acc_inf) ? acc_x : 6'd0;
  assign out_Ry    = (out_valid && !acc_inf) ? acc_y : 6'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 3'd0;
      k_r     <= 6'd0;
      px_r    <= 6'd0;
      py_r    <= 6'd0;
      prime_r <= 6'd0;
      a_r     <= 6'd0;
      acc_x   <= 6'd0;
      acc_y   <= 6'd0;
      acc_inf <= 1'b1;
      q_x     <= 6'd0;
      q_y     <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            k_r     <= in_k;
            px_r    <= in_Px;
            py_r    <= in_Py;
            prime_r <= in_prime;
            a_r     <= in_a;
            acc_inf <= 1'b1;
            idx     <= 3'd5;
            state   <= DBL;
          end
        end
        DBL: begin
          if (acc_inf) begin
            q_x   <= px_r;
            q_y   <= py_r;
            state <= ADD;
          end else if (acc_y == 6'd0) begin
            // Doubling a point with y=0 yields O without an engine call.
            acc_inf <= 1'b1;
            q_x     <= px_r;
            q_y     <= py_r;
            state   <= ADD;
          end else begin
            state <= DBL_WAIT;
          end
        end
        DBL_WAIT: begin
          if (ec_out_valid) begin
            acc_x   <= ec_Rx;
            acc_y   <= ec_Ry;
            acc_inf <= 1'b0;
            q_x     <= px_r;
            q_y     <= py_r;
            state   <= ADD;
          end
        end
        ADD: begin
          if (!k_bit) begin
            state <= NEXT;
          end else if (acc_inf) begin
            acc_x   <= px_r;
            acc_y   <= py_r;
            acc_inf <= 1'b0;
            state   <= NEXT;
          end else if (add_inv || add_two) begin
            acc_inf <= 1'b1;
            state   <= NEXT;
          end else begin
            state <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          if (ec_out_valid) begin
            acc_x   <= ec_Rx;
            acc_y   <= ec_Ry;
            acc_inf <= 1'b0;
            state   <= NEXT;
          end
        end
        NEXT: begin
          if (idx == 3'd0) begin
            state <= OUT;
          end else begin
            idx   <= idx - 3'd1;
            q_x   <= acc_x;
            q_y   <= acc_y;
            state <= DBL;
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec_scalar_ctrl.sv
// Bench for ec_scalar_ctrl: behavioural point-arithmetic engine plus a repeated-addition
// reference for k*P on y^2 = x^3 + x + 6 over GF(11).
module tb_ec_scalar_ctrl;

  typedef struct {
    int x;
    int y;
    bit inf;
  } pt_t;

  localparam int PRIME = 11;
  localparam int CA    = 1;
  localparam int CB    = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_k = '0;
  logic [5:0] in_Px = '0;
  logic [5:0] in_Py = '0;
  logic [5:0] in_prime = '0;
  logic [5:0] in_a = '0;
  logic       ec_in_valid;
  logic [5:0] ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a;
  logic       ec_out_valid = 1'b0;
  logic [5:0] ec_Rx = '0;
  logic [5:0] ec_Ry = '0;
  logic       out_valid;
  logic [5:0] out_Rx, out_Ry;
  logic       out_inf;
  logic [2:0] dbg_state;

  ec_scalar_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_k(in_k), .in_Px(in_Px),
    .in_Py(in_Py), .in_prime(in_prime), .in_a(in_a), .ec_in_valid(ec_in_valid),
    .ec_Px(ec_Px), .ec_Py(ec_Py), .ec_Qx(ec_Qx), .ec_Qy(ec_Qy), .ec_prime(ec_prime),
    .ec_a(ec_a), .ec_out_valid(ec_out_valid), .ec_Rx(ec_Rx), .ec_Ry(ec_Ry),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry), .out_inf(out_inf),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int md(input int v);
    int r;
    r = v % PRIME;
    if (r < 0) r += PRIME;
    return r;
  endfunction

  function automatic int inv(input int v);
    for (int i = 1; i < PRIME; i++)
      if (md(v * i) == 1) return i;
    return 0;
  endfunction

  function automatic pt_t pt_add(input pt_t a, input pt_t b);
    pt_t r;
    int lam;
    r.inf = 1'b0;
    r.x = 0;
    r.y = 0;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && md(a.y + b.y) == 0) begin
      r.inf = 1'b1;
      return r;
    end
    if (a.x == b.x) lam = md((3 * a.x * a.x + CA) * inv(md(2 * a.y)));
    else            lam = md((b.y - a.y) * inv(md(b.x - a.x)));
    r.x = md(lam * lam - a.x - b.x);
    r.y = md(lam * (a.x - r.x) - a.y);
    return r;
  endfunction

  function automatic pt_t ref_mul(input int k, input int px, input int py);
    pt_t r, p;
    r.inf = 1'b1; r.x = 0; r.y = 0;
    p.inf = 1'b0; p.x = px; p.y = py;
    for (int i = 0; i < k; i++) r = pt_add(r, p);
    return r;
  endfunction

  // ---------------- engine model ----------------
  int  eng_lat_fixed = 3;
  bit  eng_busy = 1'b0;
  bit  eng_abandoned = 1'b0;
  int  eng_cnt = 0;
  int  eng_calls = 0;
  int  eng_lsum = 0;
  int  ec_ov_seen = 0;
  int  hold_err = 0;
  int  param_err = 0;
  int  overlap_err = 0;
  int  cap_px, cap_py, cap_qx, cap_qy;
  pt_t eng_res;
  int  op_q[$];
  int  res_q[$];

  always @(negedge clk) begin
    pt_t a, b;
    int lat;
    ec_out_valid = 1'b0;
    ec_Rx = 6'($urandom_range(0, 63));
    ec_Ry = 6'($urandom_range(0, 63));
    if (rst_n !== 1'b1) eng_abandoned = 1'b1;
    if (eng_busy) begin
      if (!eng_abandoned && (int'(ec_Px) != cap_px || int'(ec_Py) != cap_py ||
                             int'(ec_Qx) != cap_qx || int'(ec_Qy) != cap_qy))
        hold_err++;
      eng_cnt--;
      if (eng_cnt == 0) begin
        ec_out_valid = 1'b1;
        ec_Rx = 6'(eng_res.x);
        ec_Ry = 6'(eng_res.y);
        eng_busy = 1'b0;
        ec_ov_seen++;
      end
    end
    if (ec_in_valid === 1'b1) begin
      if (eng_busy) overlap_err++;
      if (int'(ec_prime) != PRIME || int'(ec_a) != CA) param_err++;
      cap_px = int'(ec_Px); cap_py = int'(ec_Py);
      cap_qx = int'(ec_Qx); cap_qy = int'(ec_Qy);
      a.inf = 1'b0; a.x = cap_px; a.y = cap_py;
      b.inf = 1'b0; b.x = cap_qx; b.y = cap_qy;
      eng_res = pt_add(a, b);
      op_q.push_back(cap_px); op_q.push_back(cap_py);
      op_q.push_back(cap_qx); op_q.push_back(cap_qy);
      res_q.push_back(eng_res.x); res_q.push_back(eng_res.y);
      lat = (eng_lat_fixed > 0) ? eng_lat_fixed : int'($urandom_range(1, 4));
      eng_cnt = lat;
      eng_busy = 1'b1;
      eng_abandoned = 1'b0;
      eng_calls++;
      eng_lsum += lat;
    end
  end

  // out_valid must be a single-cycle pulse
  int ovw_err = 0;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_ov === 1'b1) ovw_err++;
    prev_ov = out_valid;
  end

  // ---------------- driver ----------------
  int last_calls;

  task automatic run_req(input int k, input int px, input int py, input int inject,
                         input string tag);
    pt_t exp;
    int t0, c0, l0, zero_err;
    bit got;
    exp = ref_mul(k, px, py);
    @(negedge clk);
    op_q.delete();
    res_q.delete();
    in_valid = 1'b1; in_k = 6'(k); in_Px = 6'(px); in_Py = 6'(py);
    in_prime = 6'(PRIME); in_a = 6'(CA);
    t0 = cyc; c0 = eng_calls; l0 = eng_lsum; zero_err = 0; got = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_k = 6'($urandom_range(0, 63)); in_Px = 6'($urandom_range(0, 63));
    in_Py = 6'($urandom_range(0, 63)); in_prime = 6'($urandom_range(0, 63));
    for (int n = 0; n < 400; n++) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (out_Rx !== 6'd0 || out_Ry !== 6'd0 || out_inf !== 1'b0) zero_err++;
      in_valid = (n == inject);
      @(negedge clk);
    end
    in_valid = 1'b0;
    last_calls = eng_calls - c0;
    check_val({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      check_val({tag, "_lat"}, 32'(cyc - t0), 32'(19 + eng_lsum - l0));
      check_val({tag, "_inf"}, 32'(out_inf), 32'(exp.inf));
      check_val({tag, "_rx"}, 32'(out_Rx), exp.inf ? 32'd0 : 32'(exp.x));
      check_val({tag, "_ry"}, 32'(out_Ry), exp.inf ? 32'd0 : 32'(exp.y));
      check_val({tag, "_idle_zero"}, 32'(zero_err), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ec_iv"}, 32'(ec_in_valid), 32'd0);
    check_val({tag, "_ec_ops"}, 32'({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a}), 32'd0);
    check_val({tag, "_out"}, 32'({out_valid, out_Rx, out_Ry, out_inf}), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int pts_x[$];
  int pts_y[$];

  initial begin
    int c0, ov0, bad_ov, bad_st, sel;
    bit seen;
    for (int x = 0; x < PRIME; x++)
      for (int y = 0; y < PRIME; y++)
        if (md(y * y) == md(x * x * x + CA * x + CB)) begin
          pts_x.push_back(x);
          pts_y.push_back(y);
        end

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    eng_lat_fixed = 3;
    run_req(0, 2, 7, -1, "k0");
    check_val("k0_calls", 32'(last_calls), 32'd0);
    run_req(1, 2, 7, -1, "k1");
    check_val("k1_calls", 32'(last_calls), 32'd0);
    run_req(2, 2, 7, -1, "k2");
    check_val("k2_calls", 32'(last_calls), 32'd1);
    if (op_q.size() >= 4)
      check_val("k2_ops", 32'({op_q[0][7:0], op_q[1][7:0], op_q[2][7:0], op_q[3][7:0]}),
                32'h02070207);
    else
      check_val("k2_ops_count", 32'(op_q.size()), 32'd4);
    run_req(13, 2, 7, -1, "k13");
    check_val("k13_calls", 32'(last_calls), 32'd4);
    if (res_q.size() >= 2)
      check_val("k13_last_acc", 32'({res_q[res_q.size()-2][7:0], res_q[res_q.size()-1][7:0]}),
                32'h0204);
    else
      check_val("k13_res_count", 32'(res_q.size()), 32'd8);

    // request arriving mid-computation, then one immediately after out_valid
    run_req(13, 2, 7, 6, "inj");
    run_req(5, 2, 7, -1, "b2b");

    // reset while the engine is working on an ADD
    @(negedge clk);
    in_valid = 1'b1; in_k = 6'd3; in_Px = 6'd2; in_Py = 6'd7;
    in_prime = 6'(PRIME); in_a = 6'(CA);
    c0 = eng_calls;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (eng_calls >= c0 + 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("rst_add_call_seen", 32'(seen), 32'd1);
    ov0 = ec_ov_seen;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bad_ov = 0; bad_st = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_Rx !== 6'd0 || out_Ry !== 6'd0 || out_inf !== 1'b0) bad_ov++;
      if (dbg_state !== 3'd0 || ec_in_valid !== 1'b0) bad_st++;
    end
    check_val("late_ec_out_seen", 32'(ec_ov_seen - ov0), 32'd1);
    check_val("postrst_outputs", 32'(bad_ov), 32'd0);
    check_val("postrst_idle", 32'(bad_st), 32'd0);
    run_req(7, 2, 7, -1, "postrst");

    // randomized requests with random engine latency
    eng_lat_fixed = 0;
    for (int t = 0; t < 16; t++) begin
      sel = int'($urandom_range(0, pts_x.size() - 1));
      run_req(int'($urandom_range(0, 63)), pts_x[sel], pts_y[sel],
              (t % 3 == 0) ? int'($urandom_range(0, 15)) : -1, $sformatf("rnd%0d", t));
    end

    repeat (3) @(negedge clk);
    check_val("ec_operand_hold", 32'(hold_err), 32'd0);
    check_val("ec_params", 32'(param_err), 32'd0);
    check_val("ec_overlap", 32'(overlap_err), 32'd0);
    check_val("out_pulse_width", 32'(ovw_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
